// File: rtl/draw_card.sv
// rtl/draw_card.sv - card sprite overlay on the VGA stream with per-frame deal animation
// Optional macro DRAW_CARD_BORDER_EN forces the outermost card row/column to black.
module card_rom (
    input  logic        clk,
    input  logic [17:0] addr,
    output logic [11:0] data
);
    // Procedural artwork: every 32nd word (including each card's top-left) is the transparent key.
    always_ff @(posedge clk) begin
        if (addr[4:0] == 5'd0)
            data <= 12'hF0F;
        else
            data <= {addr[17:12] ^ addr[5:0], addr[11:6]};
    end
endmodule

module draw_card #(
    parameter int          CARD_W = 48,
    parameter int          CARD_H = 64,
    parameter int          DECK_X = 700,
    parameter int          DECK_Y = 40,
    parameter int          STEP   = 4,
    parameter logic [11:0] TRANSP = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vga_in_hcount,
    input  logic [10:0] vga_in_vcount,
    input  logic        vga_in_hsync,
    input  logic        vga_in_vsync,
    input  logic        vga_in_hblnk,
    input  logic        vga_in_vblnk,
    input  logic [11:0] vga_in_rgb,
    output logic [10:0] vga_out_hcount,
    output logic [10:0] vga_out_vcount,
    output logic        vga_out_hsync,
    output logic        vga_out_vsync,
    output logic        vga_out_hblnk,
    output logic        vga_out_vblnk,
    output logic [11:0] vga_out_rgb,
    input  logic        deal_start,
    input  logic [5:0]  card_id,
    input  logic [10:0] target_x,
    input  logic [10:0] target_y,
    input  logic        clear,
    output logic        busy,
    output logic        deal_done
);
    localparam logic [1:0]         IDLE   = 2'd0;
    localparam logic [1:0]         MOVE   = 2'd1;
    localparam logic [1:0]         HOLD   = 2'd2;
    localparam logic [10:0]        DECK_X11 = 11'(DECK_X);
    localparam logic [10:0]        DECK_Y11 = 11'(DECK_Y);
    localparam logic [10:0]        STEP11 = 11'(STEP);
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic [11:0]        W12    = 12'(CARD_W);
    localparam logic [11:0]        H12    = 12'(CARD_H);

    logic [1:0]  state;
    logic [10:0] pos_x, pos_y, tgt_x, tgt_y, next_x, next_y;
    logic [5:0]  id;
    logic        vblnk_prev, tick;

    function automatic logic [10:0] step_axis(input logic [10:0] pos, input logic [10:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
        if (diff > STEP_S)
            return pos + STEP11;
        else if (diff < -STEP_S)
            return pos - STEP11;
        else
            return tgt;
    endfunction

    assign tick   = vga_in_vblnk & ~vblnk_prev;
    assign next_x = step_axis(pos_x, tgt_x);
    assign next_y = step_axis(pos_y, tgt_y);
    assign busy   = (state == MOVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pos_x      <= DECK_X11;
            pos_y      <= DECK_Y11;
            tgt_x      <= 11'd0;
            tgt_y      <= 11'd0;
            id         <= 6'd0;
            deal_done  <= 1'b0;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vga_in_vblnk;
            deal_done  <= 1'b0;
            if (clear) begin
                state <= IDLE;
            end else if (deal_start && state != MOVE) begin
                state <= MOVE;
                id    <= card_id;
                tgt_x <= target_x;
                tgt_y <= target_y;
                pos_x <= DECK_X11;
                pos_y <= DECK_Y11;
            end else if (state == MOVE && tick) begin
                // Position only moves at the start of vertical blanking so no frame is torn.
                pos_x <= next_x;
                pos_y <= next_y;
                if (next_x == tgt_x && next_y == tgt_y) begin
                    state     <= HOLD;
                    deal_done <= 1'b1;
                end
            end
        end
    end

    // Stage 1: hit test and ROM address, compared in 12 bits so pos + size cannot wrap.
    logic [11:0] hc, vc, px, py, col, row;
    logic        inside_c;
    logic [17:0] rom_addr;
    logic [11:0] rom_data;

    assign hc       = {1'b0, vga_in_hcount};
    assign vc       = {1'b0, vga_in_vcount};
    assign px       = {1'b0, pos_x};
    assign py       = {1'b0, pos_y};
    assign col      = hc - px;
    assign row      = vc - py;
    assign inside_c = (state != IDLE) && !vga_in_hblnk && !vga_in_vblnk
                   && (hc >= px) && (hc <= px + W12 - 12'd1)
                   && (vc >= py) && (vc <= py + H12 - 12'd1);
    assign rom_addr = 18'(id) * 18'(CARD_W * CARD_H) + 18'(row) * 18'(CARD_W) + 18'(col);

    card_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    logic [10:0] hcount_d, vcount_d;
    logic        hsync_d, vsync_d, hblnk_d, vblnk_d, inside_d;
    logic [11:0] rgb_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_d <= 11'd0;
            vcount_d <= 11'd0;
            hsync_d  <= 1'b0;
            vsync_d  <= 1'b0;
            hblnk_d  <= 1'b0;
            vblnk_d  <= 1'b0;
            rgb_d    <= 12'd0;
            inside_d <= 1'b0;
        end else begin
            hcount_d <= vga_in_hcount;
            vcount_d <= vga_in_vcount;
            hsync_d  <= vga_in_hsync;
            vsync_d  <= vga_in_vsync;
            hblnk_d  <= vga_in_hblnk;
            vblnk_d  <= vga_in_vblnk;
            rgb_d    <= vga_in_rgb;
            inside_d <= inside_c;
        end
    end

    // Stage 2: ROM word is valid now; composite over the background.
    logic [11:0] pix;
    logic        opaque;
    logic [11:0] rgb_c;

`ifdef DRAW_CARD_BORDER_EN
    logic border_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            border_d <= 1'b0;
        else
            border_d <= (row == 12'd0) || (row == H12 - 12'd1)
                     || (col == 12'd0) || (col == W12 - 12'd1);
    end
    assign pix    = border_d ? 12'h000 : rom_data;
    assign opaque = border_d || (rom_data != TRANSP);
`else
    assign pix    = rom_data;
    assign opaque = (rom_data != TRANSP);
`endif

    assign rgb_c = (inside_d && opaque) ? pix : rgb_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_out_hcount <= 11'd0;
            vga_out_vcount <= 11'd0;
            vga_out_hsync  <= 1'b0;
            vga_out_vsync  <= 1'b0;
            vga_out_hblnk  <= 1'b0;
            vga_out_vblnk  <= 1'b0;
            vga_out_rgb    <= 12'd0;
        end else begin
            vga_out_hcount <= hcount_d;
            vga_out_vcount <= vcount_d;
            vga_out_hsync  <= hsync_d;
            vga_out_vsync  <= vsync_d;
            vga_out_hblnk  <= hblnk_d;
            vga_out_vblnk  <= vblnk_d;
            vga_out_rgb    <= rgb_c;
        end
    end
endmodule

// File: tb/tb_draw_card.sv
// tb/tb_draw_card.sv - scoreboard bench for draw_card against a behavioural card/deal model
module tb_draw_card;
    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vga_in_hcount, vga_in_vcount, vga_out_hcount, vga_out_vcount;
    logic        vga_in_hsync, vga_in_vsync, vga_in_hblnk, vga_in_vblnk;
    logic        vga_out_hsync, vga_out_vsync, vga_out_hblnk, vga_out_vblnk;
    logic [11:0] vga_in_rgb, vga_out_rgb;
    logic        deal_start, clear, busy, deal_done;
    logic [5:0]  card_id;
    logic [10:0] target_x, target_y;

    always #5 clk = ~clk;

    draw_card dut (
        .clk            (clk),
        .rst            (rst),
        .vga_in_hcount  (vga_in_hcount),
        .vga_in_vcount  (vga_in_vcount),
        .vga_in_hsync   (vga_in_hsync),
        .vga_in_vsync   (vga_in_vsync),
        .vga_in_hblnk   (vga_in_hblnk),
        .vga_in_vblnk   (vga_in_vblnk),
        .vga_in_rgb     (vga_in_rgb),
        .vga_out_hcount (vga_out_hcount),
        .vga_out_vcount (vga_out_vcount),
        .vga_out_hsync  (vga_out_hsync),
        .vga_out_vsync  (vga_out_vsync),
        .vga_out_hblnk  (vga_out_hblnk),
        .vga_out_vblnk  (vga_out_vblnk),
        .vga_out_rgb    (vga_out_rgb),
        .deal_start     (deal_start),
        .card_id        (card_id),
        .target_x       (target_x),
        .target_y       (target_y),
        .clear          (clear),
        .busy           (busy),
        .deal_done      (deal_done)
    );

    typedef struct {
        int          due;
        logic [10:0] hc, vc;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } vexp_t;
    typedef struct {
        int   due;
        logic busy, done;
    } cexp_t;

    vexp_t vq[$];
    cexp_t cq[$];
    int    cyc = 0, tests = 0, fails = 0, done_seen = 0;
    logic  in_reset = 1'b1;

    // Reference state: mode 0 = no card, 1 = sliding, 2 = parked.
    int   m_mode, m_px, m_py, m_tx, m_ty, m_id;
    logic m_prev_vb;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] card_pixel(input int id, input int r, input int c);
        int a;
        a = id * 3072 + r * 48 + c;
        if (a % 32 == 0) return 12'hF0F;
        return {6'(((a >> 12) ^ a) & 63), 6'((a >> 6) & 63)};
    endfunction

    function automatic logic [11:0] exp_rgb(input int hc, input int vc, input logic hb,
                                            input logic vb, input logic [11:0] bg);
        int r, c;
        logic [11:0] p;
        r = vc - m_py;
        c = hc - m_px;
        if (m_mode == 0 || hb || vb || r < 0 || r >= 64 || c < 0 || c >= 48) return bg;
`ifdef DRAW_CARD_BORDER_EN
        if (r == 0 || r == 63 || c == 0 || c == 47) return 12'h000;
`endif
        p = card_pixel(m_id, r, c);
        return (p == 12'hF0F) ? bg : p;
    endfunction

    function automatic int toward(input int p, input int t);
        int d;
        d = t - p;
        if (d > 4) return 4;
        if (d < -4) return -4;
        return d;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_px = 700; m_py = 40; m_tx = 0; m_ty = 0; m_id = 0; m_prev_vb = 1'b0;
    endtask

    task automatic drive(input logic [10:0] hc, input logic [10:0] vc, input logic hb, input logic vb);
        vexp_t e;
        cexp_t c;
        logic  tick, done;
        vga_in_hcount = hc;
        vga_in_vcount = vc;
        vga_in_hblnk  = hb;
        vga_in_vblnk  = vb;
        vga_in_hsync  = 1'($urandom);
        vga_in_vsync  = 1'($urandom);
        vga_in_rgb    = 12'($urandom);
        e.due = cyc + 2;
        e.hc = hc; e.vc = vc; e.hs = vga_in_hsync; e.vs = vga_in_vsync; e.hb = hb; e.vb = vb;
        e.rgb = exp_rgb(int'(hc), int'(vc), hb, vb, vga_in_rgb);
        vq.push_back(e);
        tick = vb && !m_prev_vb;
        m_prev_vb = vb;
        done = 1'b0;
        if (clear) begin
            m_mode = 0;
        end else if (deal_start && m_mode != 1) begin
            m_mode = 1; m_px = 700; m_py = 40;
            m_id = int'(card_id); m_tx = int'(target_x); m_ty = int'(target_y);
        end else if (m_mode == 1 && tick) begin
            m_px += toward(m_px, m_tx);
            m_py += toward(m_py, m_ty);
            if (m_px == m_tx && m_py == m_ty) begin
                m_mode = 2;
                done = 1'b1;
            end
        end
        c.due = cyc + 1; c.busy = (m_mode == 1); c.done = done;
        cq.push_back(c);
        @(posedge clk);
        #1;
        deal_start = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic frame(input int n);
        int hc, vc;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                hc = m_px + int'($urandom_range(0, 55)) - 4;
                vc = m_py + int'($urandom_range(0, 71)) - 4;
            end else begin
                hc = int'($urandom_range(0, 1023));
                vc = int'($urandom_range(0, 767));
            end
            drive(11'(hc), 11'(vc), ($urandom_range(0, 15) == 0), 1'b0);
        end
        for (int i = 0; i < 3; i++)
            drive(11'($urandom_range(0, 1023)), 11'(768 + i), 1'b1, 1'b1);
    endtask

    task automatic deal(input logic [5:0] id, input logic [10:0] tx, input logic [10:0] ty);
        deal_start = 1'b1; card_id = id; target_x = tx; target_y = ty;
        drive(11'd0, 11'd0, 1'b0, 1'b0);
    endtask

    task automatic until_done(input int fsz, input int maxf, output int nf);
        int start;
        start = done_seen;
        nf = 0;
        while (done_seen == start && nf < maxf) begin
            frame(fsz);
            nf++;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!in_reset) begin
            if (vq.size() > 0 && vq[0].due == cyc) begin
                vexp_t e;
                e = vq.pop_front();
                tests++;
                if (vga_out_hcount !== e.hc || vga_out_vcount !== e.vc || vga_out_hsync !== e.hs ||
                    vga_out_vsync !== e.vs || vga_out_hblnk !== e.hb || vga_out_vblnk !== e.vb ||
                    vga_out_rgb !== e.rgb) begin
                    fails++;
                    $display("FAIL vga_out cyc=%0d got h=%0d v=%0d s=%b%b b=%b%b rgb=%h exp h=%0d v=%0d s=%b%b b=%b%b rgb=%h",
                             cyc, vga_out_hcount, vga_out_vcount, vga_out_hsync, vga_out_vsync,
                             vga_out_hblnk, vga_out_vblnk, vga_out_rgb, e.hc, e.vc, e.hs, e.vs,
                             e.hb, e.vb, e.rgb);
                end
            end
            if (cq.size() > 0 && cq[0].due == cyc) begin
                cexp_t c;
                c = cq.pop_front();
                tests++;
                if (busy !== c.busy || deal_done !== c.done) begin
                    fails++;
                    $display("FAIL ctrl cyc=%0d got busy=%b done=%b exp busy=%b done=%b",
                             cyc, busy, deal_done, c.busy, c.done);
                end
            end
            if (deal_done === 1'b1) done_seen++;
        end
    end

    initial begin
        int nf, d0;
        rst = 1'b1; deal_start = 1'b0; clear = 1'b0; card_id = 6'd0;
        target_x = 11'd0; target_y = 11'd0;
        vga_in_hcount = 11'd123; vga_in_vcount = 11'd45; vga_in_hsync = 1'b1; vga_in_vsync = 1'b1;
        vga_in_hblnk = 1'b0; vga_in_vblnk = 1'b0; vga_in_rgb = 12'hABC;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", int'(vga_out_rgb), 0);
        check("reset_hcount", int'(vga_out_hcount), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(deal_done), 0);
        rst = 1'b0;
        in_reset = 1'b0;

        frame(40); frame(40);

        deal(6'd0, 11'd600, 11'd40);
        d0 = done_seen;
        until_done(20, 40, nf);
        check("deal600_frames", nf, 25);
        frame(10);
        check("deal600_pulses", done_seen - d0, 1);

        deal(6'd7, 11'd698, 11'd37);
        d0 = done_seen;
        until_done(20, 10, nf);
        check("clamp_frames", nf, 1);
        check("clamp_busy", int'(busy), 0);

        deal(6'd5, 11'd500, 11'd200);
        frame(20); frame(20); frame(20); frame(20); frame(20);
        deal(6'd9, 11'd100, 11'd100);
        until_done(20, 80, nf);
        check("ignored_deal_frames", nf, 45);
        deal_start = 1'b1; clear = 1'b1; card_id = 6'd2; target_x = 11'd10; target_y = 11'd10;
        drive(11'd0, 11'd0, 1'b0, 1'b0);
        check("clear_beats_deal", int'(busy), 0);
        frame(30);

        deal(6'd51, 11'd1000, 11'd740);
        until_done(6, 200, nf);
        check("offscreen_frames", nf, 175);
        drive(11'd1000, 11'd740, 1'b0, 1'b0);
        drive(11'd1001, 11'd740, 1'b0, 1'b0);
        for (int h = 1018; h < 1032; h++)
            drive(11'(h), 11'd740, (h >= 1024), 1'b0);
        for (int h = 0; h < 4; h++)
            drive(11'(h), 11'd741, 1'b0, 1'b0);
        drive(11'd1000, 11'd745, 1'b0, 1'b0);
        drive(11'd1010, 11'd750, 1'b0, 1'b0);
        drive(11'd1023, 11'd767, 1'b0, 1'b0);
        frame(20);

        deal(6'd3, 11'd100, 11'd500);
        frame(20); frame(20); frame(20);
        #2;
        rst = 1'b1;
        in_reset = 1'b1;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_rgb", int'(vga_out_rgb), 0);
        check("async_rst_vblnk", int'(vga_out_vblnk), 0);
        vq.delete();
        cq.delete();
        model_reset();
        vga_in_vblnk = 1'b0;
        d0 = done_seen;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_reset = 1'b0;
        frame(30); frame(30);
        check("no_done_after_rst", done_seen - d0, 0);

        repeat (4) drive(11'd5, 11'd5, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", vq.size() + cq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
